// File: rtl/ttl_gate_tester.sv
// ttl_gate_tester
// In-circuit tester for a 14-pin triple 3-input TTL gate package (sn7410
// family). Each of the three gates is exercised in turn with all eight
// {A,B,C} vectors. The gate's output is compared against the selected gold
// function, and the block counts test cases and mismatches.
//
// Parameters
//   GOLD    gold function: 0=NAND 1=AND 2=NOR 3=OR
//   SETTLE  wait cycles between driving a vector and sampling (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a run (accepted in IDLE only)
//   gate_in      chip input pins, gate g uses gate_in[3g+2:3g] = {A,B,C}
//   gate_out     chip output pins, gate_out[g] is gate g
//   busy         run in progress
//   done         one-cycle completion pulse
//   pass         last run finished with no mismatches
//   test_count   vectors checked in this run
//   error_count  mismatches in this run (saturating)
//   fail_gate    gate index of the first mismatch
//   fail_vector  {A,B,C} of the first mismatch
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start, results held
// S_DRIVE  | put current vector on the pins of gate g
// S_SETTLE | down-count SETTLE cycles for the chip to settle
// S_CHECK  | sample gate_out[g], update counters, advance
// S_DONE   | done pulse, then back to idle
module ttl_gate_tester #(
    parameter int GOLD   = 0,
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [8:0] gate_in,
    input  logic [2:0] gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] test_count,
    output logic [7:0] error_count,
    output logic [1:0] fail_gate,
    output logic [2:0] fail_vector
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [1:0] r_gate;
    logic [2:0] r_vec;
    logic [3:0] r_wait;
    logic       r_seen_fail;
    logic [8:0] r_gate_in;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_test_count;
    logic [7:0] r_error_count;
    logic [1:0] r_fail_gate;
    logic [2:0] r_fail_vector;

    logic       w_gold;
    logic       w_sample;
    logic       w_mismatch;
    logic       w_last;
    logic [8:0] w_drive;
    logic [7:0] w_err_next;

    always_comb begin
        if (GOLD == 0)      w_gold = ~(&r_vec);
        else if (GOLD == 1) w_gold = &r_vec;
        else if (GOLD == 2) w_gold = ~(|r_vec);
        else                w_gold = |r_vec;
    end

    always_comb begin
        w_sample = gate_out[0];
        w_drive  = {6'b0, r_vec};
        case (r_gate)
            2'd1: begin
                w_sample = gate_out[1];
                w_drive  = {3'b0, r_vec, 3'b0};
            end
            2'd2: begin
                w_sample = gate_out[2];
                w_drive  = {r_vec, 6'b0};
            end
            default: ;
        endcase
    end

    // Written as "mismatch unless provably equal" so that an X/Z pin in
    // simulation lands on the mismatch side instead of silently passing.
    always_comb begin
        w_mismatch = 1'b1;
        if (w_sample == w_gold) w_mismatch = 1'b0;
    end

    assign w_err_next = (w_mismatch && (r_error_count != 8'hFF))
                        ? r_error_count + 8'd1 : r_error_count;
    assign w_last     = (r_gate == 2'd2) && (r_vec == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_gate        <= 2'd0;
            r_vec         <= 3'd0;
            r_wait        <= 4'd0;
            r_seen_fail   <= 1'b0;
            r_gate_in     <= 9'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_test_count  <= 8'd0;
            r_error_count <= 8'd0;
            r_fail_gate   <= 2'd0;
            r_fail_vector <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state       <= S_DRIVE;
                        r_busy        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_test_count  <= 8'd0;
                        r_error_count <= 8'd0;
                        r_fail_gate   <= 2'd0;
                        r_fail_vector <= 3'd0;
                        r_seen_fail   <= 1'b0;
                        r_gate        <= 2'd0;
                        r_vec         <= 3'd0;
                    end
                end
                S_DRIVE: begin
                    r_gate_in <= w_drive;
                    if (SETTLE == 0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_wait  <= LP_SETTLE - 4'd1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_wait == 4'd0) r_state <= S_CHECK;
                    else                r_wait  <= r_wait - 4'd1;
                end
                S_CHECK: begin
                    r_test_count  <= r_test_count + 8'd1;
                    r_error_count <= w_err_next;
                    if (w_mismatch && !r_seen_fail) begin
                        r_seen_fail   <= 1'b1;
                        r_fail_gate   <= r_gate;
                        r_fail_vector <= r_vec;
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 8'd0);
                    end else begin
                        r_state <= S_DRIVE;
                        if (r_vec == 3'd7) begin
                            r_vec  <= 3'd0;
                            r_gate <= r_gate + 2'd1;
                        end else begin
                            r_vec <= r_vec + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gate_in     = r_gate_in;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign test_count  = r_test_count;
    assign error_count = r_error_count;
    assign fail_gate   = r_fail_gate;
    assign fail_vector = r_fail_vector;

endmodule
